// File: rtl/tophat_uart_tx.sv
// Byte-wide UART transmitter: valid/ready input, LSB-first frame with optional
// even parity and 1 or 2 stop bits on a registered, idle-high serial line.
module tophat_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic StopLast = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic            stop_idx_q, stop_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic            tx_q, tx_d;
  logic            init_q;
  logic            bit_end;

  assign bit_end  = (cnt_q == CntLast);
  assign in_ready = init_q && (state_q == StIdle);
  assign busy     = (state_q != StIdle);
  assign tx       = tx_q;

  // tx_d always carries the value the line must hold in the bit that starts at this edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tx_d       = tx_q;

    if (state_q != StIdle) begin
      cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          state_d  = StStart;
          shift_d  = in_data;
          parity_d = ^in_data;
          cnt_d    = '0;
          tx_d     = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            stop_idx_d = 1'b0;
            if (PARITY_EN) begin
              state_d = StParity;
              tx_d    = parity_q;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d    = StStop;
          stop_idx_d = 1'b0;
          tx_d       = 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (stop_idx_q == StopLast) begin
            state_d = StIdle;
          end else begin
            stop_idx_d = 1'b1;
          end
          tx_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      stop_idx_q <= 1'b0;
      shift_q    <= 8'h00;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      init_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      init_q     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tophat_uart_tx.sv
// Bench for tophat_uart_tx: three configurations share one stimulus stream and are
// compared every cycle against a frame-level model (bit list indexed by elapsed time).
module tb_tophat_uart_tx;

  localparam int Cpb = 4;
  localparam int ParEn    [3] = '{0, 1, 0};
  localparam int StopBits [3] = '{1, 1, 2};

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       ready_w [3];
  logic       tx_w    [3];
  logic       busy_w  [3];

  int n_checks = 0;
  int n_errors = 0;

  tophat_uart_tx #(.CLKS_PER_BIT(Cpb), .PARITY_EN(1'b0), .STOP_BITS(1)) u_dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0])
  );
  tophat_uart_tx #(.CLKS_PER_BIT(Cpb), .PARITY_EN(1'b1), .STOP_BITS(1)) u_dut_p (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1])
  );
  tophat_uart_tx #(.CLKS_PER_BIT(Cpb), .PARITY_EN(1'b0), .STOP_BITS(2)) u_dut_s (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int flen(input int i);
    return (9 + ParEn[i] + StopBits[i]) * Cpb;
  endfunction

  // Frame bits LSB-first: start, data[0..7], optional parity, then ones for stop.
  function automatic logic [11:0] build_frame(input logic [7:0] d, input int par);
    logic [11:0] f;
    f       = '1;
    f[0]    = 1'b0;
    f[8:1]  = d;
    if (par != 0) f[9] = ^d;
    return f;
  endfunction

  int          rem    [3];
  logic        init_m [3];
  logic [11:0] fr     [3];
  int          bcnt   [3];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        rem[i]    <= 0;
        init_m[i] <= 1'b0;
      end else begin
        init_m[i] <= 1'b1;
        if (rem[i] > 0) begin
          rem[i] <= rem[i] - 1;
        end else if (init_m[i] && in_valid) begin
          rem[i] <= flen(i);
          fr[i]  <= build_frame(in_data, ParEn[i]);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic exp_tx;
      exp_tx = (rem[i] > 0) ? fr[i][(flen(i) - rem[i]) / Cpb] : 1'b1;
      check_eq($sformatf("tx%0d", i), 32'(tx_w[i]), 32'(exp_tx));
      check_eq($sformatf("busy%0d", i), 32'(busy_w[i]), 32'(rem[i] > 0));
      check_eq($sformatf("ready%0d", i), 32'(ready_w[i]), 32'(init_m[i] && rem[i] == 0));
      if (rst) begin
        bcnt[i] = 0;
      end else if (busy_w[i]) begin
        bcnt[i]++;
      end else if (bcnt[i] > 0) begin
        check_eq($sformatf("frame_len%0d", i), 32'(bcnt[i]), 32'(flen(i)));
        bcnt[i] = 0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int wait_cycles);
    in_data  = b;
    in_valid = 1'b1;
    cyc(1);
    in_valid = 1'b0;
    cyc(wait_cycles);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) bcnt[i] = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    cyc(3);
    rst = 1'b0;
    cyc(2);

    send(8'h55, 50);
    send(8'h07, 50);
    send(8'h03, 50);
    send(8'hA5, 50);

    // Back-to-back: valid held, data switches to 0x34 right after the first acceptance.
    in_data  = 8'h12;
    in_valid = 1'b1;
    cyc(1);
    in_data = 8'h34;
    cyc(46);
    in_valid = 1'b0;
    in_data  = 8'hEE;
    cyc(50);

    // Backpressure: a one-cycle 0xFF offer while every instance is busy.
    send(8'h3C, 10);
    in_data  = 8'hFF;
    in_valid = 1'b1;
    cyc(1);
    in_valid = 1'b0;
    cyc(60);

    repeat (3000) begin
      in_valid = ($urandom_range(0, 3) == 0);
      in_data  = 8'($urandom);
      cyc(1);
    end
    in_valid = 1'b0;
    cyc(60);

    // Reset while the start bit is on the line.
    send(8'h81, 2);
    check_eq("pre_rst_tx_low", 32'(tx_w[0]), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("rst_async_tx%0d", i), 32'(tx_w[i]), 32'd1);
      check_eq($sformatf("rst_async_busy%0d", i), 32'(busy_w[i]), 32'd0);
      check_eq($sformatf("rst_async_ready%0d", i), 32'(ready_w[i]), 32'd0);
    end
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("ready_before_edge%0d", i), 32'(ready_w[i]), 32'd0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("rst_release_ready%0d", i), 32'(ready_w[i]), 32'd1);
      check_eq($sformatf("rst_release_tx%0d", i), 32'(tx_w[i]), 32'd1);
    end
    cyc(20);

    send(8'hC3, 50);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tophat_uart_tx.md
# tophat_uart_tx

Serial transmitter for the tophat Tiny Tapeout tile. It is the outbound counterpart to the tile's parallel input path. It accepts a byte over a valid/ready handshake and shifts it out LSB-first as an asynchronous serial frame: start bit, 8 data bits, optional even parity, then 1 or 2 stop bits. It sits between the tile's core logic and one `uo_out` pin, and exposes `busy` for status.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range ≥2.
- `PARITY_EN`, 0: 1 inserts an even-parity bit after data bit 7.
- `STOP_BITS`, 1: number of stop bits; legal values 1 or 2.

- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_data` input 8: byte to send; sampled only on acceptance.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: transmitter can accept a byte this cycle.
- `tx` output 1: serial line; idles high.
- `busy` output 1: a frame is in progress.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
  - PARITY is skipped when `PARITY_EN`=0.
- Acceptance happens on a rising edge where `in_valid`=1 and `in_ready`=1.
  - `in_data` is latched into the shift register.
  - Parity is computed as XOR of the 8 bits.
  - State moves IDLE→START.
- `in_ready`=1 only in IDLE. While `in_ready`=0, `in_valid` is ignored and no byte is lost or queued; the upstream block holds its data.
- Per-state behaviour:
  - START drives `tx`=0.
  - DATA drives bit 0 first, then bits 1..7 in order.
  - PARITY drives the even-parity bit.
  - STOP drives `tx`=1 for `STOP_BITS` bit periods.
- Bit timing: a baud counter of width clog2(`CLKS_PER_BIT`) counts 0..`CLKS_PER_BIT`-1 in each bit.
  - At terminal count the next bit starts.
  - A bit index of 0..7 tracks data bits; a stop index tracks stop bits.
- `busy`=1 in every state except IDLE.
- `tx` is registered, with no combinational path from inputs to `tx`.
- When STOP completes, the state returns to IDLE and `in_ready` reasserts.
- Reset (asynchronous), immediately and for as long as `rst`=1:
  - state=IDLE, `tx`=1, `busy`=0, `in_ready`=0, counters=0.
  - `in_ready` goes to 1 on the first rising edge after `rst` deasserts; handshakes are never accepted while `rst`=1.
- Reset mid-frame aborts the frame: `tx` returns high at once and no partial frame resumes.
- `in_data` changing after acceptance has no effect on the frame in flight.

## Timing
- Acceptance edge E: `tx` goes low at E; the start bit occupies `CLKS_PER_BIT` cycles.
- Frame length is F = (1 + 8 + `PARITY_EN` + `STOP_BITS`) × `CLKS_PER_BIT` cycles, with `busy`=1 for exactly F cycles.
- `in_ready` rises in the cycle after the last stop-bit cycle.
- With `in_valid` held high, that IDLE cycle accepts the next byte. Back-to-back frames are therefore separated by exactly 1 idle cycle of `tx`=1.
- Handshake latency: at most 1 cycle from `in_ready` high to acceptance when `in_valid` is already high.
- Default parameters give 10×16=160 cycles per frame.

## Test plan
- Reset: assert `rst` mid-frame (`tx`=0 during START).
  - Required: `tx`=1, `busy`=0, `in_ready`=0 asynchronously, before the next edge.
  - Required: `in_ready`=1 one edge after release.
- Basic frame (`CLKS_PER_BIT`=4, `PARITY_EN`=0, `STOP_BITS`=1): send 0x55.
  - Required `tx` sequence, 4 cycles each: 0,1,0,1,0,1,0,1,0,1.
  - Required: `busy` high for 40 cycles.
- Parity (`PARITY_EN`=1): send 0x07 → parity bit 1; send 0x03 → parity bit 0.
  - Required: frame length 44 cycles at `CLKS_PER_BIT`=4.
- Two stop bits (`STOP_BITS`=2): send 0xA5.
  - Required: 8 cycles of `tx`=1 after data bit 7.
  - Required: `in_ready` reasserts at cycle 45 after acceptance.
- Back-to-back: hold `in_valid`=1 with 0x12 then 0x34.
  - Required: second start bit begins exactly 1 cycle after the first frame's stop bit.
  - Required: 0x34 is latched, and changes to `in_data` during frame 1 are ignored.
- Backpressure: pulse `in_valid` with 0xFF while `busy`=1.
  - Required: no acceptance, and the frame in flight is unchanged.
  - Required: line idles high afterwards and no extra frame appears.
